// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared funct3 encodings and FSM state type for the load/store
//             unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  // RV32I funct3 encodings for loads and stores (stores use B/H/W only)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Lane extraction/extension for loads and byte/half merge for
//             read-modify-write stores. Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then sign- or zero-extend it by funct3
  always_comb begin
    w_byte = word_i[{offset_i, 3'b000} +: 8];
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_o = {24'd0, w_byte};
      F3_H:    load_o = {{16{w_half[15]}}, w_half};
      F3_HU:   load_o = {16'd0, w_half};
      default: load_o = word_i;
    endcase
  end

  // Overlay the right-aligned store data onto the old word at the target lane
  always_comb begin
    merge_o = word_i;
    case (funct3_i[1:0])
      2'd0: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      2'd1: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Multi-cycle load/store initiator to a word-wide data memory.
//             Sub-word stores are performed as read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_accept;
  logic        w_err;
  logic        w_rmw;
  logic        w_sw_cycle;
  logic        w_wr_cycle;
  logic [31:0] w_align_word;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Word fed to the aligner: live memory data for loads, captured word for merge
  assign w_align_word = (state_q == WRITE) ? merge_q : mem_rd_i;

  lsu_align u_align (
    .funct3_i (f3_q),
    .offset_i (addr_q[1:0]),
    .word_i   (w_align_word),
    .wdata_i  (wdata_q),
    .load_o   (w_load),
    .merge_o  (w_merge)
  );

  // Classify the incoming request so bad ones skip the memory entirely
  always_comb begin
    logic w_mis, w_oor, w_ill;
    w_mis = ((req_funct3_i[1:0] == 2'd1) && req_addr_i[0]) ||
            ((req_funct3_i[1:0] == 2'd2) && (req_addr_i[1:0] != 2'd0));
    w_oor = {2'b00, req_addr_i[31:2]} >= c_mem_words;
    w_ill = req_we_i ? (req_funct3_i >= 3'd3)
                     : ((req_funct3_i == 3'd3) || (req_funct3_i >= 3'd6));
    w_err = w_mis || w_oor || w_ill;
  end

  assign w_accept = req_valid_i && req_ready_o;
  assign w_rmw    = we_q && (f3_q != F3_W);

  // Next-state and request/data register updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = w_err;
          state_d = w_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = w_load;
        if (w_rmw) begin
          merge_d = mem_rd_i;
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any access in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Output drive; writes are gated by reset so an aborted store never lands
  always_comb begin
    w_sw_cycle  = (state_q == ACCESS) && we_q && !w_rmw;
    w_wr_cycle  = (w_sw_cycle || (state_q == WRITE)) && !rst_i;
    req_ready_o = (state_q == IDLE) && !rst_i;
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    rsp_err_o   = (state_q == RESP) && err_q;
    mem_we_o    = w_wr_cycle;
    mem_a_o     = ((state_q == ACCESS) || (state_q == WRITE)) ? {2'b00, addr_q[31:2]} : '0;
    mem_wd_o    = '0;
    if (w_wr_cycle) mem_wd_o = (state_q == WRITE) ? w_merge : wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit with a word memory
//             model and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dmem    [0:31];
  logic [31:0] ref_mem [0:31];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_f3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_we_o     (mem_we),
    .mem_a_o      (mem_a),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_a[4:0]];

  // Data memory: bench preload port has priority over DUT writes
  always @(posedge clk) begin
    if (pl_we)       dmem[pl_idx] <= pl_val;
    else if (mem_we) dmem[mem_a[4:0]] <= mem_wd;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    int unsigned size;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    size  = 32'd1 << f3[1:0];
    return !legal || ((addr % size) != 0) || ((addr / 4) >= 32);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int unsigned v;
    v = word;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * addr[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * addr[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] mask;
    case (f3)
      3'd0: begin
        mask = 32'hFF << (8 * addr[1:0]);
        return (word & ~mask) | ((wdata & 32'hFF) << (8 * addr[1:0]));
      end
      3'd1: begin
        mask = 32'hFFFF << (16 * addr[1]);
        return (word & ~mask) | ((wdata & 32'hFFFF) << (16 * addr[1]));
      end
      default: return wdata;
    endcase
  endfunction

  // ---------------- stimulus helpers (observation only) ----------------
  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_we = 1'b1; pl_idx = 5'(idx); pl_val = val;
    @(negedge clk);
    pl_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int wcnt, output int wcyc, output logic [31:0] wd,
                       output logic [31:0] wa, output logic [31:0] a1);
    lat = 0; rdata = '0; err = 1'b0; wcnt = 0; wcyc = 0; wd = '0; wa = '0; a1 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        a1 = mem_a;
      end
      if (mem_we) begin wcnt++; wcyc = c; wd = mem_wd; wa = mem_a; end
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd} !== '0)
      begin n_bad++; $display("FAIL reset_outputs: got ready=%b vld=%b err=%b rd=%h we=%b a=%h wd=%h expected all 0",
                               req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h0D, 32'h0F, 32'h0C, 32'h0E};
    logic [2:0]  f3s   [4] = '{3'd0, 3'd4, 3'd5, 3'd1};
    logic [31:0] exps  [4] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'h0000_AABB, 32'hFFFF_8899};
    int lat, wcnt, wcyc; logic [31:0] rd, wd, wa, a1; logic err;
    preload(3, 32'h8899_AABB);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], addrs[i], 32'h0, lat, rd, err, wcnt, wcyc, wd, wa, a1);
      n_cmp++;
      if (lat !== 2 || err !== 1'b0 || rd !== exps[i] || wcnt !== 0 || a1 !== 32'd3)
        begin n_bad++; $display("FAIL load_lane[%0d]: got lat=%0d err=%b rd=%h wcnt=%0d a=%h expected lat=2 err=0 rd=%h wcnt=0 a=3",
                                 i, lat, err, rd, wcnt, a1, exps[i]); end
    end
  endtask

  task automatic test_sb_rmw();
    int lat, wcnt, wcyc; logic [31:0] rd, wd, wa, a1; logic err;
    issue(1'b1, 3'd0, 32'h0E, 32'h1234_5677, lat, rd, err, wcnt, wcyc, wd, wa, a1);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h0 || wcnt !== 1 || wcyc !== 2 ||
        wd !== 32'h8877_AABB || wa !== 32'd3 || a1 !== 32'd3)
      begin n_bad++; $display("FAIL sb_rmw: got lat=%0d err=%b rd=%h wcnt=%0d wcyc=%0d wd=%h wa=%h a1=%h expected 3 0 0 1 2 8877aabb 3 3",
                               lat, err, rd, wcnt, wcyc, wd, wa, a1); end
    ref_mem[3] = 32'h8877_AABB;
    issue(1'b0, 3'd2, 32'h0C, 32'h0, lat, rd, err, wcnt, wcyc, wd, wa, a1);
    n_cmp++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'h8877_AABB || wcnt !== 0)
      begin n_bad++; $display("FAIL sb_readback: got lat=%0d err=%b rd=%h wcnt=%0d expected 2 0 8877aabb 0",
                               lat, err, rd, wcnt); end
  endtask

  task automatic test_errors();
    logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s   [3] = '{3'd2, 3'd2, 3'd3};
    logic [31:0] addrs [3] = '{32'h06, 32'h80, 32'h0C};
    int lat, wcnt, wcyc; logic [31:0] rd, wd, wa, a1; logic err;
    for (int i = 0; i < 3; i++) begin
      issue(wes[i], f3s[i], addrs[i], 32'hDEAD_BEEF, lat, rd, err, wcnt, wcyc, wd, wa, a1);
      n_cmp++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wcnt !== 0 || a1 !== 32'h0)
        begin n_bad++; $display("FAIL error_req[%0d]: got lat=%0d err=%b rd=%h wcnt=%0d a=%h expected 1 1 0 0 0",
                                 i, lat, err, rd, wcnt, a1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic seen;
    v = 32'hCAFE_F00D;
    seen = 1'b0;
    preload(4, v);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd1; req_addr = 32'h10; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    seen = seen | rsp_valid;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rmid_write_cycle: got we=%b expected 1", mem_we); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_we_gated: got we=%b expected 0", mem_we); end
    @(negedge clk);
    seen = seen | rsp_valid;
    rst = 1'b0;
    @(negedge clk);
    seen = seen | rsp_valid;
    n_cmp++;
    if (req_ready !== 1'b1 || seen !== 1'b0 || dmem[4] !== v)
      begin n_bad++; $display("FAIL rmid_abort: got ready=%b rsp_seen=%b word4=%h expected 1 0 %h",
                               req_ready, seen, dmem[4], v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pat;
    logic [7:0]  rsp_at;
    logic [31:0] rd1, rd2, w2;
    logic        e1, e2;
    pat = 8'b1100_1001;
    rsp_at = '0; rd1 = '0; rd2 = '0; e1 = 1'b0; e2 = 1'b0;
    w2 = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h00; req_wdata = '0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      n_cmp++;
      if (req_ready !== pat[n]) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b expected %b", n, req_ready, pat[n]); end
      if (rsp_valid) begin
        rsp_at[n] = 1'b1;
        if (n == 2) begin rd1 = rsp_rdata; e1 = rsp_err; end
        if (n == 5) begin rd2 = rsp_rdata; e2 = rsp_err; end
      end
      if (n == 1) begin req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h04; req_wdata = w2; end
      if (n == 4) req_valid = 1'b0;
    end
    n_cmp++;
    if (rsp_at !== 8'b0010_0100 || rd1 !== ref_mem[0] || e1 !== 1'b0 || rd2 !== 32'h0 || e2 !== 1'b0 || dmem[1] !== w2)
      begin n_bad++; $display("FAIL b2b_responses: got at=%b rd1=%h e1=%b rd2=%h e2=%b w1=%h expected 00100100 %h 0 0 0 %h",
                               rsp_at, rd1, e1, rd2, e2, dmem[1], ref_mem[0], w2); end
    ref_mem[1] = w2;
  endtask

  task automatic test_random();
    logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic we, err, e_err;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] addr, wdata, rd, wd, wa, a1, e_rd, e_wd, e_wa, e_a1, widx;
    int idx, lat, wcnt, wcyc, e_lat, e_wcnt, e_wcyc;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      idx = $urandom_range(0, 35);
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) off = (f3[1:0] == 2'd2) ? 2'd0 : (f3[1:0] == 2'd1) ? {off[1], 1'b0} : off;
      addr = 32'(idx) * 4 + 32'(off);
      if (i % 10 == 9) addr = $urandom | 32'h8000_0000;
      wdata = $urandom;
      widx  = addr / 4;
      e_err = model_err(we, f3, addr);
      e_lat = e_err ? 1 : (we && f3 != 3'd2) ? 3 : 2;
      e_rd  = (e_err || we) ? 32'h0 : model_load(f3, addr, ref_mem[widx[4:0]]);
      e_wcnt = (!e_err && we) ? 1 : 0;
      e_wcyc = (!e_err && we) ? ((f3 == 3'd2) ? 1 : 2) : 0;
      e_wd  = (!e_err && we) ? model_store(f3, addr, ref_mem[widx[4:0]], wdata) : 32'h0;
      e_wa  = (!e_err && we) ? widx : 32'h0;
      e_a1  = e_err ? 32'h0 : widx;
      issue(we, f3, addr, wdata, lat, rd, err, wcnt, wcyc, wd, wa, a1);
      n_cmp++;
      if (lat !== e_lat || err !== e_err || rd !== e_rd || wcnt !== e_wcnt || wcyc !== e_wcyc ||
          wd !== e_wd || wa !== e_wa || a1 !== e_a1)
        begin n_bad++; $display("FAIL random[%0d] we=%b f3=%0d addr=%h: got lat=%0d err=%b rd=%h wcnt=%0d wcyc=%0d wd=%h wa=%h a1=%h expected %0d %b %h %0d %0d %h %h %h",
                                 i, we, f3, addr, lat, err, rd, wcnt, wcyc, wd, wa, a1,
                                 e_lat, e_err, e_rd, e_wcnt, e_wcyc, e_wd, e_wa, e_a1); end
      if (!e_err && we) begin
        ref_mem[widx[4:0]] = e_wd;
        n_cmp++;
        if (dmem[widx[4:0]] !== e_wd)
          begin n_bad++; $display("FAIL random_mem[%0d]: got %h expected %h", i, dmem[widx[4:0]], e_wd); end
      end
    end
  endtask

  initial begin
    test_reset();
    for (int k = 0; k < 32; k++) preload(k, $urandom);
    test_loads();
    test_sb_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
